// File: rtl/ceespu_dmem_bridge.sv
// Data-memory bridge for the ceespu core: on-chip RAM with byte-lane writes plus a
// req/ack peripheral window that stalls the core until ack or timeout.
module ceespu_dmem_bridge #(
  parameter int unsigned RAM_WORDS   = 4096,
  parameter logic [15:0] PERIPH_BASE = 16'hF000,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_e,
  input  logic [3:0]  dmem_we,
  input  logic [15:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_busy,
  output logic        per_req,
  output logic        per_we,
  output logic [3:0]  per_be,
  output logic [11:0] per_addr,
  output logic [31:0] per_wdata,
  input  logic [31:0] per_rdata,
  input  logic        per_ack,
  output logic        bus_err
);

  localparam int unsigned IdxW       = $clog2(RAM_WORDS);
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          per_we_q, per_we_d;
  logic [3:0]    per_be_q, per_be_d;
  logic [11:0]   per_addr_q, per_addr_d;
  logic [31:0]   per_wdata_q, per_wdata_d;
  logic [31:0]   cap_q, cap_d;
  logic          rd_q, rd_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [RAM_WORDS];

  logic            is_per;
  logic [IdxW-1:0] ram_idx;
  logic            ram_acc;
  logic            ram_wr;
  logic            ram_rd;

  assign is_per  = dmem_addr >= PERIPH_BASE;
  assign ram_idx = dmem_addr[IdxW+1:2];
  assign ram_acc = !rst && dmem_e && (state_q == StIdle) && !is_per;
  assign ram_wr  = ram_acc && (dmem_we != 4'b0000);
  assign ram_rd  = ram_acc && (dmem_we == 4'b0000);

  // RAM contents are intentionally outside reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_we[b]) begin
          mem_q[ram_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if (ram_rd) begin
      rdata_q <= mem_q[ram_idx];
    end else if (state_q == StDone && rd_q) begin
      rdata_q <= cap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'h0;
      per_we_q    <= 1'b0;
      per_be_q    <= 4'h0;
      per_addr_q  <= 12'h0;
      per_wdata_q <= 32'h0;
      cap_q       <= 32'h0;
      rd_q        <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_we_q    <= per_we_d;
      per_be_q    <= per_be_d;
      per_addr_q  <= per_addr_d;
      per_wdata_q <= per_wdata_d;
      cap_q       <= cap_d;
      rd_q        <= rd_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_we_d    = per_we_q;
    per_be_d    = per_be_q;
    per_addr_d  = per_addr_q;
    per_wdata_d = per_wdata_q;
    cap_d       = cap_q;
    rd_d        = rd_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      StIdle: begin
        if (dmem_e && is_per) begin
          state_d     = StReq;
          cnt_d       = 8'h0;
          per_we_d    = |dmem_we;
          per_be_d    = dmem_we;
          per_addr_d  = dmem_addr[11:0];
          per_wdata_d = dmem_wdata;
          rd_d        = (dmem_we == 4'b0000);
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        // An ack coinciding with the final counted cycle still wins over the abort.
        if (per_ack) begin
          if (rd_q) cap_d = per_rdata;
          state_d = StDone;
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          if (rd_q) cap_d = 32'hDEADBEEF;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        // The core's held request is consumed here; it never re-launches.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dmem_busy  = !rst && (((state_q == StIdle) && dmem_e && is_per) || (state_q == StReq));
  assign dmem_rdata = rdata_q;
  assign per_req    = (state_q == StReq);
  assign per_we     = per_we_q;
  assign per_be     = per_be_q;
  assign per_addr   = per_addr_q;
  assign per_wdata  = per_wdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ceespu_dmem_bridge.sv
// Scoreboard bench for ceespu_dmem_bridge: stimulus queues expected read data and
// peripheral requests; a negedge monitor pops and compares as the DUT presents them.
module tb_ceespu_dmem_bridge;

  localparam int unsigned RamWords = 4096;
  localparam int unsigned Timeout  = 15;

  logic        clk;
  logic        rst;
  logic        dmem_e;
  logic [3:0]  dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_busy;
  logic        per_req;
  logic        per_we;
  logic [3:0]  per_be;
  logic [11:0] per_addr;
  logic [31:0] per_wdata;
  logic [31:0] per_rdata;
  logic        per_ack;
  logic        bus_err;

  ceespu_dmem_bridge #(
    .RAM_WORDS  (RamWords),
    .PERIPH_BASE(16'hF000),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_e    (dmem_e),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_busy (dmem_busy),
    .per_req   (per_req),
    .per_we    (per_we),
    .per_be    (per_be),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_rdata (per_rdata),
    .per_ack   (per_ack),
    .bus_err   (bus_err)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } per_t;

  logic [31:0] rd_q[$];
  per_t        per_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cnt_req  = 0;
  int cnt_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a read accepted in one cycle is compared on the next negedge.
  logic pend_rd  = 1'b0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    per_t        p;
    if (pend_rd) begin
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got read data %h with no expected entry", dmem_rdata);
      end else begin
        e = rd_q.pop_front();
        chk("dmem_rdata", dmem_rdata, e);
      end
    end
    pend_rd = !rst && dmem_e && !dmem_busy && (dmem_we == 4'b0000);
    if (per_req && !req_prev) begin
      if (per_q.size() == 0) begin
        n_total++;
        $display("FAIL per_unexpected: got per_req addr %h with no expected entry", per_addr);
      end else begin
        p = per_q.pop_front();
        chk("per_addr", {20'h0, per_addr}, {20'h0, p.addr});
        chk("per_we", {31'h0, per_we}, {31'h0, p.we});
        chk("per_be", {28'h0, per_be}, {28'h0, p.be});
        chk("per_wdata", per_wdata, p.wdata);
      end
    end
    req_prev = per_req;
    if (per_req) cnt_req++;
    if (dmem_busy) cnt_busy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_op(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    dmem_e     = 1'b1;
    dmem_addr  = a;
    dmem_we    = we;
    dmem_wdata = wd;
    if (we == 4'b0000) rd_q.push_back(exp_rd);
    tick();
  endtask

  task automatic idle();
    dmem_e  = 1'b0;
    dmem_we = 4'b0000;
    tick();
  endtask

  // k < 0 means the peripheral never acknowledges.
  task automatic per_xact(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input int k, input logic [31:0] ack_data, input logic [31:0] exp_rd);
    per_t p;
    p.addr  = a[11:0];
    p.we    = |we;
    p.be    = we;
    p.wdata = wd;
    per_q.push_back(p);
    if (we == 4'b0000) rd_q.push_back(exp_rd);
    cnt_req    = 0;
    cnt_busy   = 0;
    dmem_e     = 1'b1;
    dmem_addr  = a;
    dmem_we    = we;
    dmem_wdata = wd;
    tick();
    if (k >= 0) begin
      repeat (k) tick();
      per_ack   = 1'b1;
      per_rdata = ack_data;
      tick();
      per_ack   = 1'b0;
    end else begin
      repeat (Timeout) tick();
    end
    tick();
    dmem_e  = 1'b0;
    dmem_we = 4'b0000;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    dmem_e     = 1'b0;
    dmem_we    = 4'b0000;
    dmem_addr  = 16'h0;
    dmem_wdata = 32'h0;
    per_rdata  = 32'h0;
    per_ack    = 1'b0;
    tick();
    tick();
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_per_req", {31'h0, per_req}, 32'h0);
    chk("rst_per_we", {31'h0, per_we}, 32'h0);
    chk("rst_per_be", {28'h0, per_be}, 32'h0);
    chk("rst_per_addr", {20'h0, per_addr}, 32'h0);
    chk("rst_per_wdata", per_wdata, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    dmem_e    = 1'b1;
    dmem_addr = 16'hF000;
    #1;
    chk("rst_busy_forced", {31'h0, dmem_busy}, 32'h0);
    dmem_e = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // RAM: full write, write-first read, byte lanes, aliasing.
    cnt_busy = 0;
    ram_op(16'h0010, 4'hF, 32'hCAFEBABE, 32'h0);
    ram_op(16'h0010, 4'h0, 32'h0, 32'hCAFEBABE);
    ram_op(16'h0020, 4'hF, 32'h11223344, 32'h0);
    ram_op(16'h0020, 4'b0001, 32'h000000AA, 32'h0);
    ram_op(16'h0020, 4'h0, 32'h0, 32'h112233AA);
    ram_op(16'h0020 + 16'(4 * RamWords), 4'h0, 32'h0, 32'h112233AA);
    ram_op(16'h0020, 4'b0100, 32'h00EE0000, 32'h0);
    ram_op(16'h0010, 4'h0, 32'h0, 32'hCAFEBABE);
    ram_op(16'h0020, 4'h0, 32'h0, 32'h11EE33AA);
    idle();
    chk("ram_busy_cycles", cnt_busy, 0);

    // Stray ack outside REQ.
    cnt_req = 0;
    per_ack = 1'b1;
    tick();
    per_ack = 1'b0;
    tick();
    chk("stray_ack_req", cnt_req, 0);

    per_xact(16'hF004, 4'h0, 32'h0, 3, 32'h12345678, 32'h12345678);
    chk("prd_req_cycles", cnt_req, 4);
    chk("prd_busy_cycles", cnt_busy, 5);
    chk("prd_bus_err", {31'h0, bus_err}, 32'h0);

    per_xact(16'hF008, 4'b1100, 32'hA5A50000, 0, 32'hFFFFFFFF, 32'h0);
    chk("pwr_req_cycles", cnt_req, 1);
    chk("pwr_busy_cycles", cnt_busy, 2);
    chk("pwr_rdata_kept", dmem_rdata, 32'h12345678);

    // Ack on the last allowed cycle counts as success.
    per_xact(16'hF010, 4'h0, 32'h0, int'(Timeout) - 1, 32'h3C3C5A5A, 32'h3C3C5A5A);
    chk("edge_req_cycles", cnt_req, Timeout);
    chk("edge_bus_err", {31'h0, bus_err}, 32'h0);

    per_xact(16'hF00C, 4'h0, 32'h0, -1, 32'h0, 32'hDEADBEEF);
    chk("to_req_cycles", cnt_req, Timeout);
    chk("to_busy_cycles", cnt_busy, Timeout + 1);
    chk("to_bus_err", {31'h0, bus_err}, 32'h1);

    ram_op(16'h0030, 4'hF, 32'h0F0F0F0F, 32'h0);
    ram_op(16'h0030, 4'h0, 32'h0, 32'h0F0F0F0F);
    idle();
    per_xact(16'hF018, 4'h0, 32'h0, 1, 32'h77665544, 32'h77665544);
    chk("sticky_bus_err", {31'h0, bus_err}, 32'h1);

    // Reset in the middle of REQ.
    per_q.push_back('{addr: 12'h014, we: 1'b0, be: 4'h0, wdata: 32'h0});
    dmem_e    = 1'b1;
    dmem_addr = 16'hF014;
    dmem_we   = 4'h0;
    tick();
    tick();
    chk("mid_req_high", {31'h0, per_req}, 32'h1);
    rst    = 1'b1;
    dmem_e = 1'b0;
    tick();
    chk("mrst_per_req", {31'h0, per_req}, 32'h0);
    chk("mrst_busy", {31'h0, dmem_busy}, 32'h0);
    chk("mrst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("mrst_rdata", dmem_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {31'h0, per_req}, 32'h0);
    ram_op(16'h0010, 4'h0, 32'h0, 32'hCAFEBABE);
    idle();
    idle();

    chk("rd_queue_empty", rd_q.size(), 0);
    chk("per_queue_empty", per_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
